// File: rtl/skid_reg.sv
// Reverse-direction elastic buffer for a valid/ready channel: ready_out comes straight from a flop,
// optionally with registered valid/data on the forward path, at full throughput.
module skid_reg #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter bit          FWD_REGISTERED  = 1'b1,
  parameter bit          GATING_FRIENDLY = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  ready_r, ready_d;
  logic                  valid_r, valid_d;
  logic [1:0]            count_r, count_d;
  logic [DATA_WIDTH-1:0] main_r, skid_r;
  logic                  load_main, load_skid, main_from_skid;
  logic                  in_fire, out_fire;

  assign in_fire  = valid_in & ready_out;
  assign out_fire = valid_out & ready_in;

  assign ready_out = ready_r;
  assign count     = count_r;
  assign valid_out = FWD_REGISTERED ? valid_r : (valid_in | (state_q == FULL));
  assign data_out  = FWD_REGISTERED ? main_r
                                    : ((state_q == FULL) ? skid_r : data_in);

  // Next-state, data-load enables and next values of the registered outputs.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    ready_d        = 1'b1;
    valid_d        = 1'b0;
    count_d        = 2'd0;

    unique case (state_q)
      EMPTY: begin
        if (FWD_REGISTERED) begin
          if (in_fire) state_d = BUSY;
          load_main = GATING_FRIENDLY ? in_fire : 1'b1;
        end else begin
          if (in_fire && !ready_in) state_d = FULL;
          load_skid = GATING_FRIENDLY ? (in_fire & ~ready_in) : ~ready_in;
        end
      end
      BUSY: begin
        if (FWD_REGISTERED) begin
          if (in_fire && !out_fire)      state_d = FULL;
          else if (!in_fire && out_fire) state_d = EMPTY;
          // Ungated mode: main_r is free to reload whenever the current beat leaves
          load_main = GATING_FRIENDLY ? (in_fire & out_fire) : ready_in;
          load_skid = GATING_FRIENDLY ? (in_fire & ~out_fire) : ~ready_in;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = FWD_REGISTERED ? BUSY : EMPTY;
          if (FWD_REGISTERED) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush wins: buffered entries are discarded and nothing new is captured
    if (flush) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end

    ready_d = (state_d != FULL);
    valid_d = (state_d != EMPTY);
    unique case (state_d)
      BUSY:    count_d = 2'd1;
      FULL:    count_d = FWD_REGISTERED ? 2'd2 : 2'd1;
      default: count_d = 2'd0;
    endcase
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      count_r <= 2'd0;
    end else begin
      state_q <= state_d;
      ready_r <= ready_d;
      valid_r <= valid_d;
      count_r <= count_d;
    end
  end

  // Payload storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (load_main) main_r <= main_from_skid ? skid_r : data_in;
    if (load_skid) skid_r <= data_in;
  end

endmodule

// File: tb/tb_skid_reg.sv
// Directed bench for skid_reg: registered-forward instance (u1) and pass-through instance (u0)
// share stimulus; each scenario checks the relevant instance against hand-computed values.
module tb_skid_reg;

  logic        clk, rst, flush, valid_in, ready_in;
  logic [15:0] data_in;
  logic        ro1, vo1, ro0, vo0;
  logic [15:0] do1, do0;
  logic [1:0]  cnt1, cnt0;

  int checks = 0;
  int failures = 0;

  skid_reg #(.DATA_WIDTH(16), .FWD_REGISTERED(1'b1), .GATING_FRIENDLY(1'b1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_out(ro1),
    .data_in(data_in), .valid_out(vo1), .ready_in(ready_in), .data_out(do1), .count(cnt1));

  skid_reg #(.DATA_WIDTH(16), .FWD_REGISTERED(1'b0), .GATING_FRIENDLY(1'b1)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_out(ro0),
    .data_in(data_in), .valid_out(vo0), .ready_in(ready_in), .data_out(do0), .count(cnt0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  logic [15:0] q[$];
  logic [15:0] exp_d;
  logic        ro_before;
  int          sent, recv, cyc;

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = 16'h0;
    do_reset();

    // Reset state
    #1;
    check("rst_ready1", 16'(ro1), 16'd1);
    check("rst_valid1", 16'(vo1), 16'd0);
    check("rst_count1", 16'(cnt1), 16'd0);

    // 1: streaming at full rate, one cycle latency
    valid_in = 1'b1; ready_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      data_in = 16'(i);
      #1;
      check("t1_ready", 16'(ro1), 16'd1);
      if (i == 1) begin
        check("t1_valid_first", 16'(vo1), 16'd0);
      end else begin
        check("t1_valid", 16'(vo1), 16'd1);
        check("t1_data", do1, 16'(i - 1));
        check("t1_count", 16'(cnt1), 16'd1);
      end
      tick();
    end
    valid_in = 1'b0;
    #1;
    check("t1_last_data", do1, 16'h0010);
    check("t1_last_valid", 16'(vo1), 16'd1);
    tick();
    check("t1_drained_valid", 16'(vo1), 16'd0);
    check("t1_drained_count", 16'(cnt1), 16'd0);

    // 2: fill both entries while stalled, then drain in order
    ready_in = 1'b0; valid_in = 1'b1; data_in = 16'hAAAA;
    tick();
    data_in = 16'hBBBB;
    #1;
    check("t2_count_one", 16'(cnt1), 16'd1);
    check("t2_ready_one", 16'(ro1), 16'd1);
    tick();
    valid_in = 1'b0; ready_in = 1'b1;
    #1;
    check("t2_count_full", 16'(cnt1), 16'd2);
    check("t2_ready_full", 16'(ro1), 16'd0);
    check("t2_data_a", do1, 16'hAAAA);
    tick();
    check("t2_data_b", do1, 16'hBBBB);
    check("t2_valid_b", 16'(vo1), 16'd1);
    check("t2_ready_after_a", 16'(ro1), 16'd1);
    tick();
    check("t2_empty_valid", 16'(vo1), 16'd0);

    // 3: random backpressure, scoreboard on order/loss/duplication
    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 6000) begin
      ro_before = ro1;
      ready_in  = 1'($urandom_range(0, 1));
      valid_in  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      data_in   = 16'(sent + 16'h0100);
      #1;
      check("t3_ready_indep", 16'(ro1), 16'(ro_before));
      check("t3_count", 16'(cnt1), 16'(q.size()));
      @(negedge clk);
      if (vo1 && ready_in) begin
        if (q.size() == 0) begin
          check("t3_unexpected_beat", do1, 16'hFFFF);
        end else begin
          exp_d = q.pop_front();
          check("t3_data", do1, exp_d);
        end
        recv++;
      end
      if (valid_in && ro1) begin
        q.push_back(data_in);
        sent++;
      end
      tick();
      cyc++;
    end
    check("t3_beats_out", 16'(recv), 16'd1000);
    valid_in = 1'b0; ready_in = 1'b1;
    repeat (3) tick();
    q.delete();

    // 4: pass-through instance
    do_reset();
    valid_in = 1'b1; ready_in = 1'b1; data_in = 16'h1234;
    #1;
    check("t4_pass_data", do0, 16'h1234);
    check("t4_pass_valid", 16'(vo0), 16'd1);
    tick();
    check("t4_count0", 16'(cnt0), 16'd0);
    check("t4_ready0", 16'(ro0), 16'd1);
    ready_in = 1'b0; data_in = 16'h5678;
    tick();
    valid_in = 1'b0;
    #1;
    check("t4_count1", 16'(cnt0), 16'd1);
    check("t4_ready_full", 16'(ro0), 16'd0);
    check("t4_skid_data", do0, 16'h5678);
    check("t4_skid_valid", 16'(vo0), 16'd1);
    ready_in = 1'b1;
    tick();
    check("t4_after_count", 16'(cnt0), 16'd0);
    check("t4_after_valid", 16'(vo0), 16'd0);
    check("t4_after_ready", 16'(ro0), 16'd1);

    // 5: flush from FULL drops the offered beat
    ready_in = 1'b0; valid_in = 1'b1; data_in = 16'h000A;
    tick();
    data_in = 16'h000B;
    tick();
    check("t5_full", 16'(cnt1), 16'd2);
    flush = 1'b1; data_in = 16'h000C;
    tick();
    flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    #1;
    check("t5_count", 16'(cnt1), 16'd0);
    check("t5_valid", 16'(vo1), 16'd0);
    check("t5_ready", 16'(ro1), 16'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_no_0c", 16'(vo1), 16'd0);
    end

    // 6: asynchronous reset while FULL, then a clean beat
    ready_in = 1'b0; valid_in = 1'b1; data_in = 16'h0011;
    tick();
    data_in = 16'h0022;
    tick();
    check("t6_full", 16'(cnt1), 16'd2);
    valid_in = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("t6_rst_valid", 16'(vo1), 16'd0);
    check("t6_rst_ready", 16'(ro1), 16'd1);
    check("t6_rst_count", 16'(cnt1), 16'd0);
    tick();
    rst = 1'b0;
    tick();
    valid_in = 1'b1; ready_in = 1'b1; data_in = 16'h7777;
    #1;
    check("t6_accept", 16'(ro1), 16'd1);
    tick();
    valid_in = 1'b0;
    #1;
    check("t6_data", do1, 16'h7777);
    check("t6_valid", 16'(vo1), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
